row_policy_adaptive: RTL
========================

# row_policy_adaptive

Per-bank DRAM row-buffer tracker with a runtime-selectable page policy (open, close, timeout) for the DRAM controller scheduler. It classifies each request against the tracked open row as hit, miss or conflict. In close and timeout modes it also issues auto-precharge requests through a valid/ack handshake. It replaces the fixed open-row tracker in front of the command generator.

## Interface
- BG_W, 2, bank-group index width
- BANK_W, 2, bank index width; NBANKS = 2^(BG_W+BANK_W)
- ROW_W, 16, row address width
- TIMEOUT, 64, idle cycles before auto-precharge in timeout mode; legal range 1..2^TMO_W-1
- TMO_W, 8, idle counter width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- refresh  in  1  refresh issued; all banks precharged
- req_en  in  1  request valid this cycle
- bank_group  in  BG_W  request bank group
- bank  in  BANK_W  request bank
- row  in  ROW_W  request row
- row_resolve  in  1  scheduler has precharged the addressed bank this cycle
- mode  in  2  00 open, 01 close, 10 timeout, 11 treated as open
- row_stat  out  2  registered: 00 idle, 01 hit, 10 miss, 11 conflict
- row_conflict  out  ROW_W  registered: open row of the last conflicting bank
- pre_req  out  1  auto-precharge request valid
- pre_bg  out  BG_W  bank group of pre_req
- pre_bank  out  BANK_W  bank of pre_req
- pre_ack  in  1  precharge accepted

## Operation
- Index = {bank_group, bank}. Each bank entry holds valid, row[ROW_W], idle[TMO_W] and pend.
- Requests are classified against the registered entry state:
  - Hit (valid, row equal): stat 01. Clear idle. If row_resolve is high, clear valid.
  - Conflict (valid, row differs): stat 11 and row_conflict = stored row. If row_resolve is high, clear valid and report stat 00 instead.
  - Miss (not valid): stat 10. Install valid=1, row, idle=0.
- Close mode: a hit or miss that leaves the entry valid sets pend on the same edge.
- Timeout mode: idle increments every cycle while valid && !pend && no access, and saturates. When idle reaches TIMEOUT, pend is set. An access clears idle, and also clears pend unless that bank is the one currently presented on pre_req.
- Open mode: pend is never set. Pend bits already set remain set and drain normally after a mode change.
- Precharge arbiter:
  - When pre_req=0, it selects the lowest-index bank with pend=1 and registers pre_req=1, pre_bg and pre_bank.
  - The selection holds stable until pre_ack.
  - On pre_ack with pre_req=1: clear valid and pend of the presented bank and deassert pre_req. A new selection may be presented from the following cycle.
- Same-bank collisions: when pre_ack and a request hit the same bank in one cycle, the request is classified from the old state, and the pre_ack invalidation wins over the request's update.
- row_resolve to a bank that has pend set clears pend. If that bank is the one currently presented, pre_req also drops on the next edge without an ack.
- Refresh has priority over everything:
  - Clears valid, idle and pend for all banks, and deasserts pre_req next cycle.
  - A concurrent request is ignored and reports stat 00.
  - A concurrent pre_ack is ignored.

## Timing
- Reset values: row_stat=0, row_conflict=0, pre_req=0, pre_bg=0, pre_bank=0, all entries cleared.
- row_stat and row_conflict are valid one cycle after req_en. row_stat is 00 in cycles with no request. row_conflict holds its value until the next conflict.
- Close mode: with access at cycle N, pend is set at the edge ending N and pre_req is high in cycle N+2 at the earliest.
- Timeout mode: with the last access at cycle N, pend is set TIMEOUT cycles later and pre_req is high one cycle after pend.
- pre_req may only drop without pre_ack on refresh or on row_resolve to the presented bank.
- Reset mid-handshake returns all state to reset values immediately.

## Configuration
- ROW_POLICY_STATS_EN defined: adds outputs hit_cnt, miss_cnt and conflict_cnt, each 32 bits.
  - Each counter increments on the registered row_stat of its class and saturates at all-ones.
  - Cleared by nRST only; not by refresh.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Open mode, req bank 3 row 0x12 twice: row_stat 10 then 01. Then row 0x34: row_stat 11 and row_conflict 0x0012. Repeat with row_resolve=1: row_stat 00 and the entry is invalid.
- Close mode, miss bank 5 row 7: pre_req=1 with pre_bg=1, pre_bank=1 two cycles later, held until pre_ack. The next req to row 7 reports 10.
- Timeout mode with TIMEOUT=4, miss bank 0, then idle: pre_req rises 5 cycles after the access edge. An intermediate hit at cycle 2 delays it by 2 cycles.
- Banks 2 and 6 pending simultaneously: bank 2 is presented first, then bank 6 after the ack. Refresh during presentation drops pre_req and leaves no pend.
- Same-cycle hit and pre_ack on the presented bank: row_stat 01, then the entry is invalid, so the next access reports 10.
- With ROW_POLICY_STATS_EN, 3 hits, 2 misses and 1 conflict give counts 3/2/1; a refresh leaves the counts unchanged.

Source files
------------

// File: rtl/row_policy_adaptive.sv
// row_policy_adaptive: per-bank DRAM row tracker with open/close/timeout page policy.
// Define ROW_POLICY_STATS_EN to add saturating hit/miss/conflict counters.
module row_policy_adaptive #(
  parameter int BG_W    = 2,
  parameter int BANK_W  = 2,
  parameter int ROW_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              refresh,
  input  logic              req_en,
  input  logic [BG_W-1:0]   bank_group,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic              row_resolve,
  input  logic [1:0]        mode,
  output logic [1:0]        row_stat,
  output logic [ROW_W-1:0]  row_conflict,
  output logic              pre_req,
  output logic [BG_W-1:0]   pre_bg,
  output logic [BANK_W-1:0] pre_bank,
  input  logic              pre_ack
`ifdef ROW_POLICY_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam int IDX_W = BG_W + BANK_W;
  localparam int NB    = 1 << IDX_W;
  localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(TIMEOUT);

  logic [NB-1:0]    valid_q, valid_d;
  logic [NB-1:0]    pend_q, pend_d;
  logic [NB-1:0]    cand;
  logic [ROW_W-1:0] row_q [NB];
  logic [ROW_W-1:0] row_d [NB];
  logic [TMO_W-1:0] idle_q [NB];
  logic [TMO_W-1:0] idle_d [NB];
  logic             pre_req_q, pre_req_d;
  logic [IDX_W-1:0] pre_idx_q, pre_idx_d;
  logic [1:0]       stat_d;
  logic [ROW_W-1:0] conf_d;
  logic [TMO_W:0]   inc;

  logic [IDX_W-1:0] idx;
  logic             acc, hit, conf, miss, ack;
  logic             close_m, tmo_m, shown;

  assign idx     = {bank_group, bank};
  assign close_m = (mode == 2'b01);
  assign tmo_m   = (mode == 2'b10);
  assign acc     = req_en & ~refresh;
  assign hit     = acc & valid_q[idx] & (row_q[idx] == row);
  assign conf    = acc & valid_q[idx] & (row_q[idx] != row);
  assign miss    = acc & ~valid_q[idx];
  assign ack     = pre_req_q & pre_ack & ~refresh;
  assign shown   = pre_req_q & (pre_idx_q == idx);

  assign pre_req  = pre_req_q;
  assign pre_bg   = pre_idx_q[IDX_W-1:BANK_W];
  assign pre_bank = pre_idx_q[BANK_W-1:0];

  always_comb begin
    valid_d   = valid_q;
    pend_d    = pend_q;
    row_d     = row_q;
    idle_d    = idle_q;
    stat_d    = 2'b00;
    conf_d    = row_conflict;
    pre_req_d = pre_req_q;
    pre_idx_d = pre_idx_q;
    cand      = '0;
    inc       = '0;
    if (tmo_m) begin
      for (int i = 0; i < NB; i++) begin
        if (valid_q[i] && !pend_q[i] && !(acc && idx == IDX_W'(i))) begin
          inc = {1'b0, idle_q[i]} + 1'b1;
          if (idle_q[i] != '1) idle_d[i] = idle_q[i] + 1'b1;
          if (inc >= TMO_LIM) pend_d[i] = 1'b1;
        end
      end
    end
    if (hit) begin
      stat_d      = 2'b01;
      idle_d[idx] = '0;
      if (row_resolve) valid_d[idx] = 1'b0;
      else if (close_m) pend_d[idx] = 1'b1;
    end
    if (conf) begin
      idle_d[idx] = '0;
      if (row_resolve) begin
        valid_d[idx] = 1'b0;
      end else begin
        stat_d = 2'b11;
        conf_d = row_q[idx];
      end
    end
    if (miss) begin
      stat_d       = 2'b10;
      valid_d[idx] = 1'b1;
      row_d[idx]   = row;
      idle_d[idx]  = '0;
      if (close_m) pend_d[idx] = 1'b1;
    end
    if (acc && tmo_m && !shown) pend_d[idx] = 1'b0;
    if (acc && row_resolve && pend_q[idx]) begin
      pend_d[idx] = 1'b0;
      if (shown) pre_req_d = 1'b0;
    end
    // only banks pending before this edge and still pending are eligible
    cand = pend_q & pend_d;
    if (!pre_req_q) begin
      pre_req_d = |cand;
      for (int i = NB-1; i >= 0; i--)
        if (cand[i]) pre_idx_d = IDX_W'(i);
    end else if (ack) begin
      valid_d[pre_idx_q] = 1'b0;
      pend_d[pre_idx_q]  = 1'b0;
      pre_req_d          = 1'b0;
    end
    if (refresh) begin
      valid_d   = '0;
      pend_d    = '0;
      pre_req_d = 1'b0;
      stat_d    = 2'b00;
      for (int i = 0; i < NB; i++) idle_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q      <= '0;
      pend_q       <= '0;
      pre_req_q    <= 1'b0;
      pre_idx_q    <= '0;
      row_stat     <= 2'b00;
      row_conflict <= '0;
      for (int i = 0; i < NB; i++) begin
        row_q[i]  <= '0;
        idle_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      pend_q       <= pend_d;
      pre_req_q    <= pre_req_d;
      pre_idx_q    <= pre_idx_d;
      row_stat     <= stat_d;
      row_conflict <= conf_d;
      for (int i = 0; i < NB; i++) begin
        row_q[i]  <= row_d[i];
        idle_q[i] <= idle_d[i];
      end
    end
  end

`ifdef ROW_POLICY_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (row_stat == 2'b01 && hit_cnt != '1)
        hit_cnt <= hit_cnt + 32'd1;
      if (row_stat == 2'b10 && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if (row_stat == 2'b11 && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
